// File: rtl/alu_pkg.sv
// Shared widths and alu_sel operation codes ({funct7[5], funct3}) for the EX/ID datapath slice.
package alu_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned PC_W      = 8;
  localparam int unsigned ALU_SEL_W = 4;

  localparam logic [ALU_SEL_W-1:0] ALU_ADD  = 4'b0000;
  localparam logic [ALU_SEL_W-1:0] ALU_SUB  = 4'b1000;
  localparam logic [ALU_SEL_W-1:0] ALU_SLL  = 4'b0001;
  localparam logic [ALU_SEL_W-1:0] ALU_SRL  = 4'b0101;
  localparam logic [ALU_SEL_W-1:0] ALU_SRA  = 4'b1101;
  localparam logic [ALU_SEL_W-1:0] ALU_SLT  = 4'b0010;
  localparam logic [ALU_SEL_W-1:0] ALU_SLTU = 4'b0011;
  localparam logic [ALU_SEL_W-1:0] ALU_XOR  = 4'b0100;
  localparam logic [ALU_SEL_W-1:0] ALU_OR   = 4'b0110;
  localparam logic [ALU_SEL_W-1:0] ALU_AND  = 4'b0111;
  localparam logic [ALU_SEL_W-1:0] ALU_PASS = 4'b1111;

endpackage

// File: rtl/alu_branch_unit_if.sv
// Operand, compare, redirect and counter signals between the pipeline and alu_branch_unit.
interface alu_branch_unit_if;
  import alu_pkg::*;

  logic [XLEN-1:0]      alu_a;
  logic [XLEN-1:0]      alu_b;
  logic [ALU_SEL_W-1:0] alu_sel;
  logic [XLEN-1:0]      alu_result;
  logic [XLEN-1:0]      cmp_a;
  logic [XLEN-1:0]      cmp_b;
  logic                 br_u;
  logic                 br_eq;
  logic                 br_lt;
  logic                 pc_sel;
  logic [XLEN-1:0]      imm;
  logic [PC_W-1:0]      id_pc;
  logic                 stall;
  logic                 branch;
  logic [PC_W-1:0]      pc_branch;
  logic [XLEN-1:0]      br_count;

  modport master (
    output alu_a, alu_b, alu_sel, cmp_a, cmp_b, br_u, pc_sel, imm, id_pc, stall,
    input  alu_result, br_eq, br_lt, branch, pc_branch, br_count
  );

  modport slave (
    input  alu_a, alu_b, alu_sel, cmp_a, cmp_b, br_u, pc_sel, imm, id_pc, stall,
    output alu_result, br_eq, br_lt, branch, pc_branch, br_count
  );

endinterface

// File: rtl/alu_core.sv
// Combinational RV32I ALU; unlisted alu_sel codes produce zero.
module alu_core
  import alu_pkg::*;
(
  input  logic [XLEN-1:0]      alu_a,
  input  logic [XLEN-1:0]      alu_b,
  input  logic [ALU_SEL_W-1:0] alu_sel,
  output logic [XLEN-1:0]      alu_result
);

  logic [4:0] shamt;
  assign shamt = alu_b[4:0];

  always_comb begin
    alu_result = '0;
    case (alu_sel)
      ALU_ADD:  alu_result = alu_a + alu_b;
      ALU_SUB:  alu_result = alu_a - alu_b;
      ALU_SLL:  alu_result = alu_a << shamt;
      ALU_SRL:  alu_result = alu_a >> shamt;
      ALU_SRA:  alu_result = XLEN'($signed(alu_a) >>> shamt);
      ALU_SLT:  alu_result = XLEN'($signed(alu_a) < $signed(alu_b));
      ALU_SLTU: alu_result = XLEN'(alu_a < alu_b);
      ALU_XOR:  alu_result = alu_a ^ alu_b;
      ALU_OR:   alu_result = alu_a | alu_b;
      ALU_AND:  alu_result = alu_a & alu_b;
      ALU_PASS: alu_result = alu_b;
      default:  alu_result = '0;
    endcase
  end

endmodule

// File: rtl/alu_branch_unit.sv
// EX ALU, branch comparator and ID redirect logic; the taken-branch counter is built
// only when BRANCH_CNT_EN is defined, otherwise br_count reads zero.
module alu_branch_unit
  import alu_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  alu_branch_unit_if.slave bus
);

  logic branch_c;
  logic unused_imm_hi;

  alu_core u_alu_core (
    .alu_a      (bus.alu_a),
    .alu_b      (bus.alu_b),
    .alu_sel    (bus.alu_sel),
    .alu_result (bus.alu_result)
  );

  assign bus.br_eq = (bus.cmp_a == bus.cmp_b);
  assign bus.br_lt = bus.br_u ? (bus.cmp_a < bus.cmp_b)
                              : ($signed(bus.cmp_a) < $signed(bus.cmp_b));

  // A stalled redirect is dropped here and re-presented by ID once the stall clears.
  assign branch_c      = bus.pc_sel & ~bus.stall;
  assign bus.branch    = branch_c;
  assign bus.pc_branch = bus.id_pc + bus.imm[PC_W-1:0];
  assign unused_imm_hi = ^bus.imm[XLEN-1:PC_W];

`ifdef BRANCH_CNT_EN
  logic [XLEN-1:0] br_count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      br_count_q <= '0;
    end else if (branch_c) begin
      br_count_q <= br_count_q + XLEN'(1);
    end
  end

  assign bus.br_count = br_count_q;
`else
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst;
  assign bus.br_count   = '0;
`endif

endmodule

// File: tb/tb_alu_branch_unit.sv
// Directed + randomized bench for alu_branch_unit against an arithmetic reference model.
module tb_alu_branch_unit;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  logic [31:0] exp_cnt;

  alu_branch_unit_if bus ();

  alu_branch_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] sel);
    int unsigned sh;
    logic [63:0] ext;
    sh  = b % 32;
    ext = {{32{a[31]}}, a};
    case (sel)
      4'd0:    return a + b;
      4'd8:    return a - b;
      4'd1:    return a * (32'd1 << sh);
      4'd5:    return a / (32'd1 << sh);
      4'd13: begin ext = ext >> sh; return ext[31:0]; end
      4'd2:    return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      4'd3:    return (a < b) ? 32'd1 : 32'd0;
      4'd4:    return a ^ b;
      4'd6:    return a | b;
      4'd7:    return a & b;
      4'd15:   return b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic ref_lt(input logic [31:0] a, input logic [31:0] b, input logic u);
    if (u) return a < b;
    return int'(a) < int'(b);
  endfunction

  // Drive all inputs, then compare every combinational output with the model.
  task automatic apply(input logic [31:0] a, input logic [31:0] b, input logic [3:0] sel,
                       input logic [31:0] ca, input logic [31:0] cb, input logic u,
                       input logic psel, input logic stl, input logic [7:0] pc,
                       input logic [31:0] im);
    logic [31:0] tgt;
    bus.alu_a = a; bus.alu_b = b; bus.alu_sel = sel;
    bus.cmp_a = ca; bus.cmp_b = cb; bus.br_u = u;
    bus.pc_sel = psel; bus.stall = stl; bus.id_pc = pc; bus.imm = im;
    #1;
    tgt = 32'(pc) + im;
    check("alu_result", bus.alu_result, ref_alu(a, b, sel));
    check("br_eq", 32'(bus.br_eq), 32'(ca == cb));
    check("br_lt", 32'(bus.br_lt), 32'(ref_lt(ca, cb, u)));
    check("branch", 32'(bus.branch), 32'(psel && !stl));
    check("pc_branch", 32'(bus.pc_branch), tgt % 256);
  endtask

  // One clock: update the expected count at the edge, check it at the next falling edge.
  task automatic tick();
    @(posedge clk);
`ifdef BRANCH_CNT_EN
    if (!rst && bus.pc_sel && !bus.stall) exp_cnt = exp_cnt + 32'd1;
`endif
    @(negedge clk);
    check("br_count", bus.br_count, exp_cnt);
  endtask

  initial begin
    total = 0; bad = 0; exp_cnt = 32'd0;
    rst = 1'b1;
    bus.alu_a = '0; bus.alu_b = '0; bus.alu_sel = '0; bus.cmp_a = '0; bus.cmp_b = '0;
    bus.br_u = 1'b0; bus.pc_sel = 1'b0; bus.stall = 1'b0; bus.id_pc = '0; bus.imm = '0;
    #2;
    check("rst_count", bus.br_count, 32'd0);
    // combinational paths follow inputs even while reset is held
    apply(32'd5, 32'd7, 4'b0000, 32'd1, 32'd1, 1'b0, 1'b1, 1'b0, 8'h20, 32'd4);
    @(negedge clk);
    check("rst_hold_count", bus.br_count, 32'd0);
    rst = 1'b0;

    // taken branches count, stalled ones do not
    apply(32'h7FFFFFFF, 32'd1, 4'b0000, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, 8'h10, 32'hFFFFFFF8);
    check("add_ovf", bus.alu_result, 32'h80000000);
    check("pc_back", 32'(bus.pc_branch), 32'h08);
    repeat (3) tick();
`ifdef BRANCH_CNT_EN
    check("count3", bus.br_count, 32'd3);
`else
    check("count_off", bus.br_count, 32'd0);
`endif
    apply(32'd0, 32'd1, 4'b1000, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1, 8'h10, 32'hFFFFFFF8);
    check("sub_wrap", bus.alu_result, 32'hFFFFFFFF);
    check("stall_branch", 32'(bus.branch), 32'd0);
    repeat (2) tick();

    // asynchronous reset mid-cycle, held across an edge with a taken branch
    bus.stall = 1'b0;
    #3 rst = 1'b1;
    #1 check("async_rst", bus.br_count, 32'd0);
    exp_cnt = 32'd0;
    tick();
    rst = 1'b0;

    // directed ALU / comparator / redirect corners
    apply(32'h80000000, 32'h21, 4'b1101, 32'hFFFFFFFF, 32'd1, 1'b0, 1'b0, 1'b0, 8'hFC, 32'd8);
    check("sra", bus.alu_result, 32'hC0000000);
    check("slt_signed_lt", 32'(bus.br_lt), 32'd1);
    check("pc_wrap", 32'(bus.pc_branch), 32'h04);
    apply(32'h80000000, 32'h21, 4'b0101, 32'hFFFFFFFF, 32'd1, 1'b1, 1'b0, 1'b0, 8'h00, 32'd0);
    check("srl", bus.alu_result, 32'h40000000);
    check("unsigned_lt", 32'(bus.br_lt), 32'd0);
    apply(32'd0, 32'h12345000, 4'b1111, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 8'h00, 32'd0);
    check("pass_b", bus.alu_result, 32'h12345000);
    check("eq_signed", {31'd0, bus.br_eq, 31'd0, bus.br_lt} == 64'h1_00000000 ? 32'd1 : 32'd0, 32'd1);
    apply(32'hFFFFFFFF, 32'd1, 4'b1010, 32'hDEADBEEF, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 8'h00, 32'd0);
    check("code1010", bus.alu_result, 32'd0);
    apply(32'hFFFFFFFF, 32'd1, 4'b0010, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 8'h00, 32'd0);
    check("slt", bus.alu_result, 32'd1);
    apply(32'hFFFFFFFF, 32'd1, 4'b0011, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 8'h00, 32'd0);
    check("sltu", bus.alu_result, 32'd0);
    tick();

    // randomized sweep over every alu_sel code, with equal compare operands now and then
    for (int i = 0; i < 300; i++) begin
      logic [31:0] a, b, ca, cb;
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
      ca = $urandom;
      cb = ($urandom_range(0, 3) == 0) ? ca : $urandom;
      apply(a, b, 4'($urandom_range(0, 15)), ca, cb, 1'($urandom), 1'($urandom),
            1'($urandom), 8'($urandom), $urandom);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_branch_unit.md
# alu_branch_unit

Combinational execute/decode datapath slice for the 5-stage RV32I pipeline: a 32-bit ALU (EX stage), a branch comparator, and the branch-target/redirect logic (ID stage). It produces the ALU result, equal/less-than flags, and the PC redirect request with its 8-bit target. An optional taken-branch counter is the only sequential logic.

## Interface
- No parameters; XLEN fixed at 32, PC width fixed at 8.
- Reset `rst` is asynchronous and active-high; the clock is `clk`.
- clk  in  1  clock; used only by the counter.
- rst  in  1  async active-high reset; used only by the counter.
- alu_a  in  32  ALU operand A (forwarded rs1 or PC).
- alu_b  in  32  ALU operand B (forwarded rs2 or immediate).
- alu_sel  in  4  operation select.
- alu_result  out  32  ALU output.
- cmp_a, cmp_b  in  32 each  branch compare operands (forwarded rs1/rs2).
- br_u  in  1  1 = unsigned compare, 0 = signed.
- br_eq  out  1  cmp_a == cmp_b.
- br_lt  out  1  cmp_a < cmp_b.
- pc_sel  in  1  control unit requests PC redirect.
- imm  in  32  sign-extended branch/jump immediate.
- id_pc  in  8  PC of the instruction in ID.
- stall  in  1  hazard unit stall.
- branch  out  1  redirect taken; flushes IF/ID.
- pc_branch  out  8  redirect target.
- br_count  out  32  taken-branch count (see Configuration).

## Operation
- alu_sel encoding {funct7[5], funct3}:
  - 0000 ADD a+b; 1000 SUB a−b.
  - 0001 SLL a<<b[4:0]; 0101 SRL logical; 1101 SRA arithmetic (shift amount always b[4:0]).
  - 0010 SLT signed, 0011 SLTU unsigned; result 32'd1 or 32'd0.
  - 0100 XOR; 0110 OR; 0111 AND.
  - 1111 PASS B (LUI).
  - All other codes (1001, 1010, 1011, 1100, 1110) give 0.
- ADD/SUB wrap modulo 2^32; no overflow flag.
- alu_sel 0000 (stall bubble) must be harmless: plain ADD.
- br_eq = (cmp_a == cmp_b).
- br_lt = br_u ? unsigned(cmp_a) < unsigned(cmp_b) : signed(cmp_a) < signed(cmp_b).
- branch = pc_sel & ~stall. A stall suppresses the redirect; it is re-evaluated when the stall releases.
- pc_branch = id_pc + imm[7:0], wrapping mod 256. It is always driven, regardless of branch. JALR targets are out of scope for this block.

## Timing
- All outputs except br_count are purely combinational: zero latency, no internal state.
- No reset value applies to combinational outputs; they follow their inputs during reset.
- br_count resets asynchronously to 0. It increments by 1 on each posedge clk where branch = 1 and rst = 0, wrapping from 0xFFFFFFFF to 0.
- If rst is asserted in the same cycle as a taken branch, rst wins and the count stays 0.

## Configuration
- `BRANCH_CNT_EN` defined: br_count is implemented as described.
- `BRANCH_CNT_EN` undefined: br_count is tied to 32'd0, and clk/rst are unused. The port list is identical in both builds.

## Structure
- Shared package `alu_pkg`: localparams for the 11 alu_sel codes plus ALU_SEL_W = 4, XLEN = 32, PC_W = 8.
- One sub-module, `alu_core` (alu_a, alu_b, alu_sel → alu_result).
- Comparator, redirect logic and counter live in the top module.

## Test plan
- ALU sweep:
  - ADD 0x7FFFFFFF+1 → 0x80000000.
  - SUB 0 − 1 → 0xFFFFFFFF.
  - SRA 0x80000000 by b = 0x21 → 0xC0000000 (only b[4:0]=1 used).
  - SRL same operands → 0x40000000.
  - PASS B 0x12345000 → 0x12345000.
  - Code 1010 → 0.
- Set-less-than and compare with a = 0xFFFFFFFF, b = 1:
  - SLT → 1, SLTU → 0.
  - Comparator: br_u = 0 gives br_lt = 1; br_u = 1 gives br_lt = 0; br_eq = 0.
  - a = b = 0xDEADBEEF: br_eq = 1, br_lt = 0 in both modes.
- Redirect:
  - pc_sel = 1, stall = 0, id_pc = 0x10, imm = 0xFFFFFFF8 → branch = 1, pc_branch = 0x08.
  - Same with stall = 1 → branch = 0, pc_branch = 0x08.
- Wrap: id_pc = 0xFC, imm = 8 → pc_branch = 0x04.
- Counter (with `BRANCH_CNT_EN`):
  - 3 clocks with branch = 1 → br_count = 3.
  - Assert rst mid-clock (asynchronously) → br_count = 0 immediately.
  - Clocks with stall = 1 → no increment.
- Without the macro: br_count stays 0 under the same stimulus.
